// File: rtl/control_store_loader_if.sv
// Byte-stream input and control-store write/read port bundle for the microcode loader.
// master = loader side, slave = host stream source plus control store.
interface control_store_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 36
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              cs_wen;
  logic [ADDR_W-1:0] cs_waddr;
  logic [DATA_W-1:0] cs_wdata;
  logic              cs_ren;
  logic [ADDR_W-1:0] cs_raddr;
  logic [DATA_W-1:0] cs_rdata;

  modport master (
    input  in_valid, in_data, cs_rdata,
    output in_ready, cs_wen, cs_waddr, cs_wdata, cs_ren, cs_raddr
  );

  modport slave (
    output in_valid, in_data, cs_rdata,
    input  in_ready, cs_wen, cs_waddr, cs_wdata, cs_ren, cs_raddr
  );
endinterface

// File: rtl/control_store_loader.sv
// MIC-1 control store loader: packs 5 LE bytes into a 36-bit word, writes it 1 cycle after the last byte, optional read-back check.
// in_ready is high only while collecting bytes; stalls the stream during write/read/check.
module control_store_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 36,
  parameter bit VERIFY = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W:0]     word_count,
  control_store_loader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err_fmt,
  output logic                err_verify,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [ADDR_W:0]     words_written
);

  localparam int NB       = (DATA_W + 7) / 8;
  localparam int BI_W     = (NB > 1) ? $clog2(NB) : 1;
  localparam int TOP_BITS = DATA_W - 8 * (NB - 1);
  // Bits of the last byte that fall outside the word must be zero.
  localparam logic [7:0] FMT_MASK = 8'hFF << TOP_BITS;
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [BI_W-1:0] LAST_IDX  = BI_W'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    READ,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W:0]   remaining, remaining_nxt;
  logic [BI_W-1:0]   idx, idx_nxt;
  logic [DATA_W-1:0] asm_word, asm_word_nxt;

  logic              load, wr_go, rd_go, fmt_set, ver_set;

  logic              cs_wen_q, cs_ren_q;
  logic [ADDR_W-1:0] cs_waddr_q, cs_raddr_q;
  logic [DATA_W-1:0] cs_wdata_q;
  logic              err_fmt_q, err_verify_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [ADDR_W:0]   words_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    idx_nxt       = idx;
    asm_word_nxt  = asm_word;
    load          = 1'b0;
    wr_go         = 1'b0;
    rd_go         = 1'b0;
    fmt_set       = 1'b0;
    ver_set       = 1'b0;

    case (state)
      IDLE, ERR: begin
        if (start) begin
          load          = 1'b1;
          addr_nxt      = start_addr;
          remaining_nxt = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
          idx_nxt       = '0;
          state_nxt     = (word_count == '0) ? DONE : RECV;
        end
      end

      RECV: begin
        if (bus.in_valid) begin
          for (int k = 0; k < NB - 1; k++) begin
            if (idx == BI_W'(k)) begin
              asm_word_nxt[8*k +: 8] = bus.in_data;
            end
          end
          if (idx == LAST_IDX) begin
            asm_word_nxt[DATA_W-1 -: TOP_BITS] = bus.in_data[TOP_BITS-1:0];
            idx_nxt = '0;
            if ((bus.in_data & FMT_MASK) != 8'h00) begin
              fmt_set   = 1'b1;
              state_nxt = ERR;
            end else begin
              wr_go     = 1'b1;
              state_nxt = WRITE;
            end
          end else begin
            idx_nxt = idx + BI_W'(1);
          end
        end
      end

      WRITE: begin
        if (VERIFY) begin
          rd_go     = 1'b1;
          state_nxt = READ;
        end else begin
          addr_nxt      = addr + ADDR_W'(1);
          remaining_nxt = remaining - (ADDR_W+1)'(1);
          state_nxt     = (remaining == (ADDR_W+1)'(1)) ? DONE : RECV;
        end
      end

      READ: begin
        state_nxt = CHECK;
      end

      // Read data is registered in the control store, so it lands here.
      CHECK: begin
        if (bus.cs_rdata != asm_word) begin
          ver_set   = 1'b1;
          state_nxt = ERR;
        end else begin
          addr_nxt      = addr + ADDR_W'(1);
          remaining_nxt = remaining - (ADDR_W+1)'(1);
          state_nxt     = (remaining == (ADDR_W+1)'(1)) ? DONE : RECV;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      remaining    <= '0;
      idx          <= '0;
      asm_word     <= '0;
      cs_wen_q     <= 1'b0;
      cs_ren_q     <= 1'b0;
      cs_waddr_q   <= '0;
      cs_raddr_q   <= '0;
      cs_wdata_q   <= '0;
      err_fmt_q    <= 1'b0;
      err_verify_q <= 1'b0;
      err_addr_q   <= '0;
      words_q      <= '0;
    end else begin
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      idx       <= idx_nxt;
      asm_word  <= asm_word_nxt;
      cs_wen_q  <= wr_go;
      cs_ren_q  <= rd_go;
      if (wr_go) begin
        cs_waddr_q <= addr;
        cs_wdata_q <= asm_word_nxt;
      end
      if (rd_go) begin
        cs_raddr_q <= addr;
      end
      if (load) begin
        err_fmt_q    <= 1'b0;
        err_verify_q <= 1'b0;
        err_addr_q   <= '0;
        words_q      <= '0;
      end else begin
        if (wr_go) begin
          words_q <= words_q + (ADDR_W+1)'(1);
        end
        if (fmt_set) begin
          err_fmt_q  <= 1'b1;
          err_addr_q <= addr;
        end
        if (ver_set) begin
          err_verify_q <= 1'b1;
          err_addr_q   <= addr;
        end
      end
    end
  end

  assign bus.in_ready = (state == RECV);
  assign bus.cs_wen   = cs_wen_q;
  assign bus.cs_waddr = cs_waddr_q;
  assign bus.cs_wdata = cs_wdata_q;
  assign bus.cs_ren   = cs_ren_q;
  assign bus.cs_raddr = cs_raddr_q;

  assign busy          = (state == RECV) || (state == WRITE) ||
                         (state == READ) || (state == CHECK);
  assign done          = (state == DONE);
  assign err_fmt       = err_fmt_q;
  assign err_verify    = err_verify_q;
  assign err_addr      = err_addr_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_control_store_loader.sv
// Bench for control_store_loader: behavioural control store plus a word-level model of each load.
module tb_control_store_loader;
  localparam int AW = 9;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, err_fmt, err_verify;
  logic [AW-1:0] err_addr;
  logic [AW:0]   words_written;

  control_store_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  control_store_loader #(.ADDR_W(AW), .DATA_W(DW), .VERIFY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .bus(bus), .busy(busy), .done(done),
    .err_fmt(err_fmt), .err_verify(err_verify), .err_addr(err_addr),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0]    mem [0:511];
  bit               corrupt_en = 1'b0;
  logic [AW+DW-1:0] wr_q [$];
  int               done_cnt = 0;
  logic             ren_d = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] rand_word();
    return {4'h0, 4'($urandom), $urandom};
  endfunction

  // Control store: synchronous write, registered read, optional bit-35 fault at address 7.
  always @(posedge clk) begin
    if (bus.cs_wen) mem[bus.cs_waddr] <= bus.cs_wdata;
    if (bus.cs_ren)
      bus.cs_rdata <= mem[bus.cs_raddr] ^
                      ((corrupt_en && bus.cs_raddr == 9'd7) ? {1'b1, 35'd0} : 36'd0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cs_wen) wr_q.push_back({bus.cs_waddr, bus.cs_wdata});
      if (done) done_cnt++;
      if (bus.cs_wen || bus.cs_ren || ren_d) chk("rdy_low_busy", bus.in_ready, 0);
      if (bus.cs_wen || bus.cs_ren) chk("wen_ren_excl", bus.cs_wen & bus.cs_ren, 0);
    end
    ren_d <= bus.cs_ren & rst_n;
  end

  // Runs one load and compares the write log and final flags with the word-level model.
  task automatic run_load(input string tag, input int sa, input int cnt,
                          input logic [39:0] w[$], input int gap_pct, input int glitch_at);
    logic [AW+DW-1:0] exp_q [$];
    logic [7:0]       bytes [$];
    bit               efmt, ever, timed_out, glitched;
    int               eaddr, ewr, n, a, bi, exp_done;
    logic [39:0]      cw;

    efmt = 0; ever = 0; eaddr = 0; ewr = 0;
    n = (cnt > 512) ? 512 : cnt;
    for (int i = 0; i < n; i++) begin
      a  = (sa + i) % 512;
      cw = w[i];
      if (cw[39:36] != 4'h0) begin efmt = 1; eaddr = a; break; end
      exp_q.push_back({9'(a), cw[35:0]});
      ewr++;
      if (corrupt_en && a == 7) begin ever = 1; eaddr = a; break; end
    end
    exp_done = (efmt || ever) ? 0 : 1;
    foreach (w[i]) begin
      cw = w[i];
      for (int k = 0; k < 5; k++) bytes.push_back(cw[8*k +: 8]);
    end

    wr_q.delete();
    done_cnt = 0; bi = 0; glitched = 0; timed_out = 1;
    @(negedge clk);
    start = 1'b1; start_addr = AW'(sa); word_count = (AW+1)'(cnt);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 0 && cnt == 0) chk({tag, "_done_next"}, done, 1);
      if (!busy) begin timed_out = 0; break; end
      start = 1'b0;
      if (glitch_at >= 0 && !glitched && bi == glitch_at) begin
        start = 1'b1; start_addr = AW'(sa + 77); word_count = 1; glitched = 1;
      end
      bus.in_valid = (bi < bytes.size()) && ($urandom_range(0, 99) >= gap_pct);
      bus.in_data  = bus.in_valid ? bytes[bi] : 8'($urandom);
      if (bus.in_valid && bus.in_ready) bi++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);

    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk({tag, "_wr"}, wr_q[i], exp_q[i]);
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
    chk({tag, "_err_fmt"}, err_fmt, efmt);
    chk({tag, "_err_verify"}, err_verify, ever);
    if (efmt || ever) chk({tag, "_err_addr"}, err_addr, eaddr);
    chk({tag, "_words"}, words_written, ewr);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] ws [$];
    logic [39:0] tw;
    logic [7:0]  b1 [5];
    int          sa;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_cs_wen", bus.cs_wen, 0);
    chk("rst_cs_ren", bus.cs_ren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_fmt", err_fmt, 0);
    chk("rst_err_verify", err_verify, 0);
    chk("rst_words", words_written, 0);
    chk("rst_waddr", bus.cs_waddr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, cycle by cycle from the last byte (cycle T).
    b1 = '{8'h29, 8'h00, 8'h00, 8'h00, 8'h00};
    start = 1'b1; start_addr = 9'd3; word_count = 10'd1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_rdy", bus.in_ready, 1);
    chk("t1_busy", busy, 1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = b1[k];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("t1_wen", bus.cs_wen, 1);
    chk("t1_waddr", bus.cs_waddr, 3);
    chk("t1_wdata", bus.cs_wdata, 36'h000000029);
    chk("t1_words_w", words_written, 1);
    @(negedge clk);
    chk("t1_ren", bus.cs_ren, 1);
    chk("t1_raddr", bus.cs_raddr, 3);
    chk("t1_wen_off", bus.cs_wen, 0);
    @(negedge clk);
    chk("t1_done_early", done, 0);
    chk("t1_busy_chk", busy, 1);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_err_fmt", err_fmt, 0);
    chk("t1_err_ver", err_verify, 0);
    chk("t1_words", words_written, 1);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_waddr_hold", bus.cs_waddr, 3);

    ws = '{40'h0123456789, 40'h0FEDCBA987, 40'h00000000FF};
    run_load("wrap", 510, 3, ws, 30, -1);

    ws.delete();
    repeat (4) ws.push_back(rand_word());
    run_load("bp", int'($urandom_range(0, 511)), 4, ws, 50, -1);

    ws.delete();
    repeat (3) ws.push_back(rand_word());
    tw = ws[1]; tw[39:32] = 8'h1F; ws[1] = tw;
    sa = int'($urandom_range(0, 500));
    run_load("fmt", sa, 3, ws, 20, -1);

    ws.delete();
    ws.push_back(rand_word());
    run_load("fmt_clear", sa + 5, 1, ws, 10, -1);

    corrupt_en = 1'b1;
    ws.delete();
    repeat (3) ws.push_back(rand_word());
    run_load("ver", 6, 3, ws, 0, -1);
    corrupt_en = 1'b0;

    ws.delete();
    run_load("zero", 100, 0, ws, 0, -1);

    ws.delete();
    repeat (2) ws.push_back(rand_word());
    run_load("glitch", 20, 2, ws, 10, 3);

    // Reset after three bytes of a word: outputs clear, nothing written.
    ws.delete();
    ws.push_back(rand_word());
    wr_q.delete();
    @(negedge clk);
    start = 1'b1; start_addr = 9'd40; word_count = 10'd2;
    @(negedge clk);
    start = 1'b0;
    tw = rand_word();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = tw[8*k +: 8];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_rdy", bus.in_ready, 0);
    chk("mrst_wen", bus.cs_wen, 0);
    chk("mrst_words", words_written, 0);
    chk("mrst_waddr", bus.cs_waddr, 0);
    chk("mrst_wdata", bus.cs_wdata, 0);
    chk("mrst_nwr", wr_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_load("post_rst", 40, 1, ws, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/control_store_loader.md
Name: control_store_loader

Overview:
- Writer side of the MIC-1 control store: fills the 512x36 microcode memory through its write port, then optionally reads each word back through its read port to verify it.
- Accepts microcode as a byte stream (valid/ready), assembles one 36-bit microinstruction from 5 bytes, and writes it at consecutive addresses.
- Sits between the host/boot interface and control_store; the microsequencer takes over the read port only after the loader reports done.

Parameters:
- ADDR_W, 9, control store address width (depth = 2**ADDR_W)
- DATA_W, 36, microinstruction width; bytes per word NB = ceil(DATA_W/8) = 5
- VERIFY, 1, 1 = read back and compare every written word; 0 = write only

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a load; ignored while busy
- start_addr  in  ADDR_W  first control store address, sampled on start
- word_count  in  ADDR_W+1  number of words to load, sampled on start
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts a byte this cycle
- cs_wen  out  1  control store write enable
- cs_waddr  out  ADDR_W  control store write address
- cs_wdata  out  DATA_W  control store write data
- cs_ren  out  1  control store read enable
- cs_raddr  out  ADDR_W  control store read address
- cs_rdata  in  DATA_W  control store registered read data
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- err_fmt  out  1  sticky; a byte 4 upper nibble was nonzero
- err_verify  out  1  sticky; read-back mismatch
- err_addr  out  ADDR_W  address of the failing word
- words_written  out  ADDR_W+1  count of words written in the current load

Behaviour:
- Reset: all outputs 0, state IDLE, byte index 0.
- States: IDLE, RECV, WRITE, READ, CHECK, DONE, ERR.
- IDLE: on start, latch addr=start_addr and remaining=min(word_count,512); clear err_fmt, err_verify, err_addr and words_written; busy=1.
  - If word_count==0, go to DONE with no writes.
  - Otherwise go to RECV.
- RECV: in_ready=1. A byte transfers when in_valid&&in_ready.
  - Bytes are little-endian: byte k fills bits [8k+7:8k]; byte 4 bits [3:0] fill bits [35:32].
  - If byte 4 bits [7:4] != 0: go to ERR, set err_fmt=1 and err_addr=addr, and write nothing.
  - After byte 4 transfers (cycle T), go to WRITE.
- WRITE (T+1): cs_wen=1 for exactly one cycle with cs_waddr=addr and cs_wdata=the assembled word; words_written+=1.
  - VERIFY=0: addr+=1 and remaining-=1, then go to RECV, or to DONE if remaining reaches 0. in_ready returns at T+2.
  - VERIFY=1: go to READ.
- READ (T+2): cs_ren=1 for exactly one cycle with cs_raddr=addr. Go to CHECK.
- CHECK (T+3): compare cs_rdata with the held word.
  - Mismatch: go to ERR, set err_verify=1 and err_addr=addr.
  - Match: addr+=1 and remaining-=1, then go to RECV (in_ready at T+4), or to DONE.
- Address wraps modulo 2**ADDR_W (511 -> 0) and is not an error.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- ERR: busy=0, done stays 0, error flags hold. A new start clears them and begins a new load.
- Strobes: cs_wen and cs_ren are never high in the same cycle. cs_waddr, cs_raddr and cs_wdata hold their last values when idle.
- in_ready is 0 in every state except RECV. A byte offered while in_ready=0 is not consumed.
- start while busy is ignored, with no effect on state or latched values.
- rst_n asserted mid-load returns to IDLE immediately and drops any partially assembled word. No write occurs unless cs_wen was already high in that cycle.

Test Plan:
- Load one word: start_addr=3, word_count=1, bytes 29,00,00,00,00 -> cs_wen at T+1 with waddr=3, wdata=0x000000029; cs_ren at T+2; done at T+4; err flags 0; words_written=1.
- Wrap-around: start_addr=510, word_count=3, words 0x123456789, 0xFEDCBA987, 0x0000000FF -> writes at addresses 510, 511, 0; all verify; done pulses once; words_written=3.
- Backpressure: in_valid toggles 1/0 randomly during a 4-word load -> only handshaken bytes are assembled, data is correct, and in_ready is low during WRITE/READ/CHECK.
- Format error: word 2 byte 4 = 0x1F -> err_fmt=1, err_addr=start_addr+1, no cs_wen for word 2, done stays 0; a following start clears err_fmt.
- Verify error: model corrupts bit 35 on read of address 7 -> err_verify=1, err_addr=7, load stops, busy=0.
- Edge cases: word_count=0 gives done one cycle later with no cs_wen; start pulsed mid-load is ignored; rst_n low after byte 2 leaves all outputs at 0 and no write.
